// File: rtl/risc_seq_ctrl.sv
// +------------------------------------------------------------------------+
// | risc_seq_ctrl: fetch/decode/execute sequencer for the 8-bit RISC core   |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

module risc_seq_ctrl #(
  parameter int WAIT_MAX = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             mem_rdy,
  output logic             rd,
  output logic             wr,
  output logic             load_ir_hi,
  output logic             load_ir_lo,
  output logic             inc_pc,
  output logic             load_pc,
  output logic             alu_ena,
  output logic             load_acc,
  output logic             datactl_ena,
  output logic             halt,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH_HI = 4'd1,
    S_FETCH_LO = 4'd2,
    S_DECODE   = 4'd3,
    S_MEM_RD   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_JUMP     = 4'd7,
    S_SKIP1    = 4'd8,
    S_SKIP2    = 4'd9,
    S_RETIRE   = 4'd10,
    S_HALT     = 4'd11,
    S_BUS_ERR  = 4'd12
  } state_t;

  localparam logic [2:0] c_op_hlt  = 3'b000;
  localparam logic [2:0] c_op_skz  = 3'b001;
  localparam logic [2:0] c_op_add  = 3'b010;
  localparam logic [2:0] c_op_andd = 3'b011;
  localparam logic [2:0] c_op_xorr = 3'b100;
  localparam logic [2:0] c_op_lda  = 3'b101;
  localparam logic [2:0] c_op_sto  = 3'b110;

  localparam int WW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WW-1:0] c_wait_max = WW'(WAIT_MAX);

  state_t           r_state;
  state_t           w_next;
  logic [WW-1:0]    r_wait;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_cnt;

  logic w_rd, w_wr, w_ld_hi, w_ld_lo, w_inc_pc, w_ld_pc;
  logic w_alu_ena, w_ld_acc, w_dctl, w_halt, w_bus, w_timeout;

  // Timeout fires only when the counter already sits at the limit and memory is still not ready.
  assign w_timeout = (WAIT_MAX > 0) && !mem_rdy && (r_wait == c_wait_max);

  always_comb begin
    w_next    = r_state;
    w_rd      = 1'b0;
    w_wr      = 1'b0;
    w_ld_hi   = 1'b0;
    w_ld_lo   = 1'b0;
    w_inc_pc  = 1'b0;
    w_ld_pc   = 1'b0;
    w_alu_ena = 1'b0;
    w_ld_acc  = 1'b0;
    w_dctl    = 1'b0;
    w_halt    = 1'b0;
    w_bus     = 1'b0;
    case (r_state)
      S_IDLE: if (ena) w_next = S_FETCH_HI;
      S_FETCH_HI: begin
        w_rd  = 1'b1;
        w_bus = 1'b1;
        if (mem_rdy) begin
          w_ld_hi  = 1'b1;
          w_inc_pc = 1'b1;
          w_next   = S_FETCH_LO;
        end else if (w_timeout) begin
          w_next = S_BUS_ERR;
        end
      end
      S_FETCH_LO: begin
        w_rd  = 1'b1;
        w_bus = 1'b1;
        if (mem_rdy) begin
          w_ld_lo  = 1'b1;
          w_inc_pc = 1'b1;
          w_next   = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_BUS_ERR;
        end
      end
      S_DECODE: begin
        case (opcode)
          c_op_hlt:  w_next = S_HALT;
          c_op_skz:  w_next = zero ? S_SKIP1 : S_RETIRE;
          c_op_add,
          c_op_andd,
          c_op_xorr,
          c_op_lda:  w_next = S_MEM_RD;
          c_op_sto:  w_next = S_MEM_WR;
          default:   w_next = S_JUMP;
        endcase
      end
      S_MEM_RD: begin
        w_rd  = 1'b1;
        w_bus = 1'b1;
        if (mem_rdy) begin
          w_alu_ena = 1'b1;
          w_next    = S_ALU_WB;
        end else if (w_timeout) begin
          w_next = S_BUS_ERR;
        end
      end
      S_ALU_WB: begin
        w_ld_acc = 1'b1;
        w_next   = S_RETIRE;
      end
      S_MEM_WR: begin
        w_wr   = 1'b1;
        w_dctl = 1'b1;
        w_bus  = 1'b1;
        if (mem_rdy)        w_next = S_RETIRE;
        else if (w_timeout) w_next = S_BUS_ERR;
      end
      S_JUMP: begin
        w_ld_pc = 1'b1;
        w_next  = S_RETIRE;
      end
      S_SKIP1: begin
        w_inc_pc = 1'b1;
        w_next   = S_SKIP2;
      end
      S_SKIP2: begin
        w_inc_pc = 1'b1;
        w_next   = S_RETIRE;
      end
      S_RETIRE:  w_next = ena ? S_FETCH_HI : S_IDLE;
      S_HALT:    w_halt = 1'b1;
      S_BUS_ERR: w_halt = 1'b1;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_bus_err <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      // A bus state held over the edge is a wait cycle; any other transition restarts the count.
      if (w_bus && (w_next == r_state)) begin
        if (r_wait != c_wait_max) r_wait <= r_wait + WW'(1);
      end else begin
        r_wait <= '0;
      end
      if (w_next == S_BUS_ERR) r_bus_err <= 1'b1;
      if (r_state == S_RETIRE) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign rd          = w_rd      & ~rst;
  assign wr          = w_wr      & ~rst;
  assign load_ir_hi  = w_ld_hi   & ~rst;
  assign load_ir_lo  = w_ld_lo   & ~rst;
  assign inc_pc      = w_inc_pc  & ~rst;
  assign load_pc     = w_ld_pc   & ~rst;
  assign alu_ena     = w_alu_ena & ~rst;
  assign load_acc    = w_ld_acc  & ~rst;
  assign datactl_ena = w_dctl    & ~rst;
  assign halt        = w_halt    & ~rst;
  assign bus_err     = r_bus_err;
  assign instr_cnt   = r_cnt;
  assign state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_risc_seq_ctrl.sv
// +------------------------------------------------------------------------+
// | tb_risc_seq_ctrl: directed self-checking bench for risc_seq_ctrl        |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_risc_seq_ctrl;

  logic       clk, rst, ena, zero, mem_rdy;
  logic [2:0] opcode;
  logic       rd, wr, load_ir_hi, load_ir_lo, inc_pc, load_pc;
  logic       alu_ena, load_acc, datactl_ena, halt, bus_err;
  logic [1:0] instr_cnt;
  logic [3:0] state;
  logic [9:0] strobes;

  int checks = 0;
  int errors = 0;

  risc_seq_ctrl #(.WAIT_MAX(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .mem_rdy(mem_rdy), .rd(rd), .wr(wr), .load_ir_hi(load_ir_hi),
    .load_ir_lo(load_ir_lo), .inc_pc(inc_pc), .load_pc(load_pc),
    .alu_ena(alu_ena), .load_acc(load_acc), .datactl_ena(datactl_ena),
    .halt(halt), .bus_err(bus_err), .instr_cnt(instr_cnt), .state(state)
  );

  assign strobes = {rd, wr, load_ir_hi, load_ir_lo, inc_pc, load_pc,
                    alu_ena, load_acc, datactl_ena, halt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, then present mem_rdy for the new cycle and let outputs settle.
  task automatic step(input logic rdy);
    @(posedge clk);
    #1;
    mem_rdy = rdy;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; ena = 1'b1; mem_rdy = 1'b1; zero = 1'b0; opcode = 3'b010;
    @(posedge clk);
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++;
    if (strobes !== 10'd0) begin errors++; $display("FAIL reset_strobes got %b want 0", strobes); end
    checks++;
    if (instr_cnt !== 2'd0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL reset_cnt_err got cnt=%0d err=%b want 0/0", instr_cnt, bus_err);
    end
    rst = 1'b0; ena = 1'b0; mem_rdy = 1'b0;
  endtask

  task automatic test_add;
    int exp_s[6] = '{1, 2, 3, 4, 5, 10};
    test_reset();
    ena = 1'b1; opcode = 3'b010;
    for (int c = 0; c < 6; c++) begin
      step(1'b1);
      checks++;
      if (state !== 4'(exp_s[c])) begin errors++; $display("FAIL add_state c=%0d got %0d want %0d", c, state, exp_s[c]); end
      checks++;
      if (alu_ena !== (c == 3) || load_acc !== (c == 4)) begin
        errors++; $display("FAIL add_pulses c=%0d got alu=%b acc=%b", c, alu_ena, load_acc);
      end
      if (c == 5) ena = 1'b0;
    end
    step(1'b1);
    checks++;
    if (state !== 4'd0 || instr_cnt !== 2'd1) begin
      errors++; $display("FAIL add_retire got state=%0d cnt=%0d want 0/1", state, instr_cnt);
    end
  endtask

  task automatic test_wait_states;
    int rd_n = 0, ld_n = 0, inc_n = 0;
    test_reset();
    ena = 1'b1; opcode = 3'b010;
    for (int c = 0; c < 3; c++) begin
      step(c == 2);
      checks++;
      if (state !== 4'd1) begin errors++; $display("FAIL wait_fh_state c=%0d got %0d want 1", c, state); end
      rd_n += int'(rd); ld_n += int'(load_ir_hi); inc_n += int'(inc_pc);
    end
    checks++;
    if (rd_n != 3 || ld_n != 1 || inc_n != 1) begin
      errors++; $display("FAIL wait_fh_counts got rd=%0d ld=%0d inc=%0d want 3/1/1", rd_n, ld_n, inc_n);
    end
    rd_n = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b0);
      checks++;
      if (state !== 4'd2) begin errors++; $display("FAIL timeout_fl_state c=%0d got %0d want 2", c, state); end
      rd_n += int'(rd);
    end
    checks++;
    if (rd_n != 5) begin errors++; $display("FAIL timeout_rd_cycles got %0d want 5", rd_n); end
    for (int c = 0; c < 4; c++) begin
      ena = c[0];
      step(1'b1);
      checks++;
      if (state !== 4'd12 || bus_err !== 1'b1 || halt !== 1'b1 || rd !== 1'b0) begin
        errors++; $display("FAIL bus_err_hold c=%0d got state=%0d err=%b halt=%b rd=%b", c, state, bus_err, halt, rd);
      end
    end
    test_reset();
    checks++;
    if (halt !== 1'b0) begin errors++; $display("FAIL bus_err_clear_halt got %b want 0", halt); end
  endtask

  task automatic test_wait_boundary;
    test_reset();
    ena = 1'b1; opcode = 3'b010;
    for (int c = 0; c < 5; c++) begin
      step(c == 4);
      checks++;
      if (state !== 4'd1 || load_ir_hi !== (c == 4)) begin
        errors++; $display("FAIL boundary_fh c=%0d got state=%0d ld=%b", c, state, load_ir_hi);
      end
    end
    step(1'b1);
    checks++;
    if (state !== 4'd2 || bus_err !== 1'b0) begin
      errors++; $display("FAIL boundary_done got state=%0d err=%b want 2/0", state, bus_err);
    end
  endtask

  task automatic test_skz;
    int exp_t[6] = '{1, 2, 3, 8, 9, 10};
    int exp_n[4] = '{1, 2, 3, 10};
    int inc_n = 0;
    test_reset();
    ena = 1'b1; opcode = 3'b001; zero = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(1'b1);
      checks++;
      if (state !== 4'(exp_t[c])) begin errors++; $display("FAIL skz_taken_state c=%0d got %0d want %0d", c, state, exp_t[c]); end
      inc_n += int'(inc_pc);
      if (c == 5) ena = 1'b0;
    end
    checks++;
    if (inc_n != 4) begin errors++; $display("FAIL skz_taken_inc got %0d want 4", inc_n); end
    test_reset();
    ena = 1'b1; opcode = 3'b001; zero = 1'b0; inc_n = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1);
      checks++;
      if (state !== 4'(exp_n[c])) begin errors++; $display("FAIL skz_not_state c=%0d got %0d want %0d", c, state, exp_n[c]); end
      inc_n += int'(inc_pc);
      if (c == 3) ena = 1'b0;
    end
    checks++;
    if (inc_n != 2) begin errors++; $display("FAIL skz_not_inc got %0d want 2", inc_n); end
  endtask

  task automatic test_sto_jmp;
    int   exp_s[6] = '{1, 2, 3, 6, 6, 10};
    logic rdy_p[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int   exp_j[5] = '{1, 2, 3, 7, 10};
    int   wr_n = 0, dc_n = 0, rd_n = 0, pc_n = 0;
    test_reset();
    ena = 1'b1; opcode = 3'b110;
    for (int c = 0; c < 6; c++) begin
      step(rdy_p[c]);
      checks++;
      if (state !== 4'(exp_s[c])) begin errors++; $display("FAIL sto_state c=%0d got %0d want %0d", c, state, exp_s[c]); end
      wr_n += int'(wr); dc_n += int'(datactl_ena);
      if (state == 4'd6) rd_n += int'(rd);
      if (c == 5) ena = 1'b0;
    end
    checks++;
    if (wr_n != 2 || dc_n != 2 || rd_n != 0) begin
      errors++; $display("FAIL sto_counts got wr=%0d dctl=%0d rd=%0d want 2/2/0", wr_n, dc_n, rd_n);
    end
    test_reset();
    ena = 1'b1; opcode = 3'b111;
    for (int c = 0; c < 5; c++) begin
      step(1'b1);
      checks++;
      if (state !== 4'(exp_j[c]) || load_pc !== (c == 3)) begin
        errors++; $display("FAIL jmp c=%0d got state=%0d load_pc=%b want %0d", c, state, load_pc, exp_j[c]);
      end
      pc_n += int'(load_pc);
      if (c == 4) ena = 1'b0;
    end
    checks++;
    if (pc_n != 1) begin errors++; $display("FAIL jmp_pulses got %0d want 1", pc_n); end
  endtask

  task automatic test_halt_and_abort;
    int exp_s[10] = '{1, 2, 3, 4, 5, 10, 1, 2, 3, 11};
    test_reset();
    ena = 1'b1; opcode = 3'b010;
    for (int c = 0; c < 10; c++) begin
      step(1'b1);
      checks++;
      if (state !== 4'(exp_s[c])) begin errors++; $display("FAIL halt_seq c=%0d got %0d want %0d", c, state, exp_s[c]); end
      if (c == 5) opcode = 3'b000;
    end
    for (int c = 0; c < 20; c++) begin
      ena = c[0];
      step(c[1]);
      checks++;
      if (state !== 4'd11 || halt !== 1'b1 || instr_cnt !== 2'd1 || strobes !== 10'b1) begin
        errors++; $display("FAIL halt_hold c=%0d got state=%0d halt=%b cnt=%0d strobes=%b", c, state, halt, instr_cnt, strobes);
      end
    end
    test_reset();
    ena = 1'b1; opcode = 3'b010;
    for (int c = 0; c < 9; c++) step(1'b1);
    step(1'b0);
    checks++;
    if (state !== 4'd4 || instr_cnt !== 2'd1) begin
      errors++; $display("FAIL abort_setup got state=%0d cnt=%0d want 4/1", state, instr_cnt);
    end
    rst = 1'b1; mem_rdy = 1'b1;
    #1;
    checks++;
    if (strobes !== 10'd0) begin errors++; $display("FAIL abort_gated got %b want 0", strobes); end
    @(posedge clk);
    #1;
    rst = 1'b0; ena = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || instr_cnt !== 2'd0 || strobes !== 10'd0) begin
      errors++; $display("FAIL abort_after got state=%0d cnt=%0d strobes=%b", state, instr_cnt, strobes);
    end
  endtask

  task automatic test_back_to_back;
    int   exp_s[6] = '{1, 2, 3, 4, 5, 10};
    logic [1:0] exp_c[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    test_reset();
    ena = 1'b1; opcode = 3'b010;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 6; c++) begin
        step(1'b1);
        checks++;
        if (state !== 4'(exp_s[c])) begin errors++; $display("FAIL b2b_state i=%0d c=%0d got %0d want %0d", i, c, state, exp_s[c]); end
        if (c == 0 && i > 0) begin
          checks++;
          if (instr_cnt !== exp_c[i-1]) begin errors++; $display("FAIL b2b_cnt i=%0d got %0d want %0d", i, instr_cnt, exp_c[i-1]); end
        end
        if (i == 4 && c == 2) ena = 1'b0;
      end
    end
    step(1'b1);
    checks++;
    if (state !== 4'd0 || instr_cnt !== exp_c[4]) begin
      errors++; $display("FAIL b2b_final got state=%0d cnt=%0d want 0/%0d", state, instr_cnt, exp_c[4]);
    end
    step(1'b1);
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL b2b_idle got %0d want 0", state); end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; zero = 1'b0; mem_rdy = 1'b0; opcode = 3'b000;
    test_reset();
    test_add();
    test_wait_states();
    test_wait_boundary();
    test_skz();
    test_sto_jmp();
    test_halt_and_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/risc_seq_ctrl.md
Name: risc_seq_ctrl

Overview:
Instruction sequencer for the 8-bit RISC CPU core; it drives the fetch/decode/execute phases around the ALU, accumulator, PC, IR and memory bus.
- Issues bus strobes, IR/PC/ACC load enables and the one-cycle ALU enable pulse.
- Handles memory wait states through a ready handshake with timeout.
- Counts retired instructions.
- Opcode map: HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111.

Parameters:
- WAIT_MAX, 4: maximum cycles a bus phase waits for mem_rdy before bus error; 0 disables the timeout.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- ena  in  1  run enable; sampled in IDLE and RETIRE.
- opcode  in  3  IR[15:13]; valid from DECODE onward.
- zero  in  1  accumulator-is-zero flag.
- mem_rdy  in  1  memory completes the current rd/wr this cycle.
- rd  out  1  memory read strobe.
- wr  out  1  memory write strobe.
- load_ir_hi  out  1  capture bus byte into IR[15:8].
- load_ir_lo  out  1  capture bus byte into IR[7:0].
- inc_pc  out  1  PC += 1.
- load_pc  out  1  PC <= IR[12:0].
- alu_ena  out  1  ALU operand-capture enable (one-cycle pulse).
- load_acc  out  1  ACC <= alu_out.
- datactl_ena  out  1  drive ACC onto data bus.
- halt  out  1  CPU halted.
- bus_err  out  1  sticky bus timeout flag.
- instr_cnt  out  CNT_W  retired instruction count.
- state  out  4  current state code (debug).

Behaviour:
- Clocking and reset
  - Single clock domain.
  - rst sampled on the rising clk edge. After that edge: state=IDLE, instr_cnt=0, bus_err=0, wait counter=0.
  - All strobe outputs are combinational decodes of the state register and mem_rdy, forced 0 while rst=1.
  - rst mid-instruction aborts immediately. No partial strobes are issued after the reset edge.
- State codes: IDLE=0, FETCH_HI=1, FETCH_LO=2, DECODE=3, MEM_RD=4, ALU_WB=5, MEM_WR=6, JUMP=7, SKIP1=8, SKIP2=9, RETIRE=10, HALT=11, BUS_ERR=12. Codes 13-15 go to IDLE on the next edge.
- IDLE: all strobes 0. ena=1 -> FETCH_HI.
- FETCH_HI: rd=1. In the cycle mem_rdy=1: load_ir_hi=1, inc_pc=1, then -> FETCH_LO.
- FETCH_LO: rd=1. In the cycle mem_rdy=1: load_ir_lo=1, inc_pc=1, then -> DECODE.
- DECODE (1 cycle, no strobes). Next state by opcode:
  - HLT -> HALT.
  - SKZ: zero=1 -> SKIP1; zero=0 -> RETIRE.
  - ADD/ANDD/XORR/LDA -> MEM_RD.
  - STO -> MEM_WR.
  - JMP -> JUMP.
- MEM_RD: rd=1. In the cycle mem_rdy=1: alu_ena=1, then -> ALU_WB.
- ALU_WB: load_acc=1 for exactly 1 cycle (ALU output is registered, so it is valid here), then -> RETIRE.
- MEM_WR: datactl_ena=1 for the whole state; wr=1 until mem_rdy=1. On mem_rdy -> RETIRE; datactl_ena drops in RETIRE.
- JUMP: load_pc=1 for 1 cycle, then -> RETIRE.
- SKIP1, SKIP2: inc_pc=1 each (skips one 2-byte instruction). SKIP1 -> SKIP2 -> RETIRE.
- RETIRE: instr_cnt += 1, wrapping modulo 2^CNT_W. ena=1 -> FETCH_HI; ena=0 -> IDLE. ena deasserting mid-instruction does not abort the instruction.
- HALT: halt=1, all other strobes 0, instr_cnt not incremented. Exit only via rst; ena ignored.
- Wait counter
  - Cleared on entry to any bus state (FETCH_HI, FETCH_LO, MEM_RD, MEM_WR).
  - Increments each cycle the state is held with mem_rdy=0.
  - If WAIT_MAX>0 and the counter reaches WAIT_MAX with mem_rdy still 0: -> BUS_ERR, bus_err<=1.
  - mem_rdy=1 on the WAIT_MAX-th wait cycle completes normally; no error.
- BUS_ERR: all strobes 0, halt=1, bus_err=1. Exit only via rst.
- Zero-wait memory (mem_rdy tied 1): ALU op = 6 cycles (FETCH_HI, FETCH_LO, DECODE, MEM_RD, ALU_WB, RETIRE). STO/JMP = 5 cycles. SKZ not taken = 4 cycles; taken = 6 cycles.
- mem_rdy outside bus states is ignored.

Test Plan:
1. Reset then ena=1, mem_rdy=1, opcode=ADD -> state sequence 1,2,3,4,5,10. alu_ena high only in the state-4 cycle; load_acc high only in state 5; instr_cnt=1 after RETIRE.
2. mem_rdy held 0 for 2 cycles in FETCH_HI (WAIT_MAX=4) -> rd high 3 cycles; load_ir_hi and inc_pc pulse once, in the third cycle. mem_rdy never asserted -> BUS_ERR after 4 wait cycles, bus_err=1, halt=1; rst clears both.
3. SKZ with zero=1 -> inc_pc pulses in FETCH_HI, FETCH_LO, SKIP1, SKIP2 (4 total). With zero=0 -> 2 pulses and state 3 -> 10.
4. STO with mem_rdy delayed 1 cycle -> datactl_ena high 2 cycles, wr high 2 cycles, rd 0 throughout MEM_WR. JMP -> load_pc single pulse in state 7.
5. HLT -> state 11, halt=1 held 20 cycles regardless of ena, instr_cnt unchanged. Assert rst mid-MEM_RD -> next state 0, all strobes 0, instr_cnt=0.
6. CNT_W=2, run 5 ADD instructions back-to-back with ena=1 -> instr_cnt 1,2,3,0,1. Drop ena during instruction 5 -> instruction completes, then IDLE.
